dataflow_byte_packer: RTL and testbench
=======================================

# dataflow_byte_packer

Downstream consumer of the byte-wide pipelined output stage. Collects a stream of 8-bit bytes qualified by a level `valid`, packs them little-endian into `BYTES_PER_WORD`-byte words, and hands the words to a 32-bit-class consumer over a valid/ready handshake through a small synchronous FIFO. The byte side has no backpressure, so FIFO overflow is detected and reported rather than prevented.

## Interface
- `BYTES_PER_WORD`, default 4: bytes per output word; ≥ 2.
- `FIFO_DEPTH`, default 4: output FIFO entries; power of 2, ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_in` in 8: byte from the upstream stage.
- `in_valid` in 1: `data_in` is accepted on every rising edge where this is high.
- `flush` in 1: single-cycle pulse; emit the partially filled word.
- `out_data` out 8*BYTES_PER_WORD: head-of-FIFO word; lane 0 = bits [7:0].
- `out_keep` out BYTES_PER_WORD: one bit per lane; set for each lane that holds a valid byte.
- `out_valid` out 1: FIFO is not empty.
- `out_ready` in 1: consumer accepts the head word when `out_valid` is also high.
- `overflow` out 1: sticky; set when a word is dropped. Cleared only by reset.
- `fill_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Assembler.**
  - Lane counter `lane` runs 0..BYTES_PER_WORD-1.
  - An accepted byte is written to lane `lane`, its keep bit is set, and `lane` increments.
  - When the byte lands in the last lane, the word is pushed with `out_keep` all ones, and the assembler clears (`lane` = 0, keep = 0).
- **Flush.**
  - If the assembler holds at least one byte, it pushes the partial word. Unfilled lanes read 0 and their keep bits are 0. The assembler then clears.
  - `flush` together with `in_valid` in the same cycle: the byte is written first, and the resulting word (partial or complete) is pushed once.
  - `flush` with an empty assembler and no accepted byte: no push, no effect.
- **FIFO.**
  - Push occurs when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - A push while full without a pop drops the word and sets `overflow`. The assembler still clears, so the byte stream is never stalled.
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle leave `fill_level` unchanged.
- **Output stability.** `out_data` and `out_keep` are held stable while `out_valid` is high and `out_ready` is low.
- **Reset.** All outputs are 0: `out_data`, `out_keep`, `out_valid`, `overflow`, `fill_level`. The assembler and the FIFO pointers are cleared.
- **Reset mid-operation.** Asserting `rst_n` low discards both the partial word and the FIFO contents immediately (asynchronous).

## Timing
- Byte completing a word, or `flush`, at edge N: word is visible at the FIFO output, with `out_valid` high, after edge N. This is 1-cycle latency when the FIFO was empty.
- The FIFO head is registered storage. There is no combinational path from `data_in` or `in_valid` to `out_data`.
- There is no combinational path from `out_ready` to any output, except that the FIFO state updates at the next edge.
- Sustained throughput: one word per BYTES_PER_WORD byte cycles. The FIFO never fills if `out_ready` is held high.
- `overflow` rises the cycle after the drop edge.
- Pointer wrap-around uses an extra MSB for full/empty discrimination:
  - full = MSBs differ and the index bits are equal;
  - empty = pointers are equal.

## Structure
- Package `dataflow_byte_packer_pkg`:
  - `BYTE_W` = 8;
  - function `lane_mask(lane)` returning the keep mask for a partial word;
  - typedef `packed_word_t` as a struct of data plus keep, parameterised via localparams in the package for the default width.
- Sub-module `dataflow_sync_fifo`: parameterised width/depth, push/pop, full/empty/level. It stores `{keep, data}` as one entry and is reused elsewhere in the dataflow path.
- The top holds the assembler counter, the lane registers, the flush merge and the overflow flag.

## Test plan
- **Full words.** Reset, `out_ready`=1, bytes 0x11,0x22,0x33,0x44 on consecutive cycles → one word 0x44332211, keep 4'b1111, `out_valid` high for exactly 1 cycle.
- **Partial flush.** Bytes 0xAA,0xBB, then `flush` alone → word 0x0000BBAA, keep 4'b0011; a following `flush` with an empty assembler → no word.
- **Flush with byte.** `flush` and byte 0xCC in the same cycle after 0xAA,0xBB → single word 0x00CCBBAA, keep 4'b0111.
- **Overflow.** `out_ready`=0, 5 full words streamed (FIFO_DEPTH=4) → `fill_level`=4, 5th word dropped, `overflow`=1. Then raise `out_ready` → first 4 words drain in order, `overflow` stays 1.
- **Full with pop.** FIFO full while a word completes in the same cycle `out_ready`=1 pops → no drop, `fill_level` stays 4, `overflow` stays 0.
- **Reset mid-word.** Assert `rst_n` low after 2 bytes and with 2 words queued → outputs 0 immediately. After release, bytes 0x01..0x04 → 0x04030201, keep 4'b1111.

Source files
------------

// File: rtl/dataflow_byte_packer_pkg.sv
// Shared types and helpers for the byte-packing stage of the dataflow path.
package dataflow_byte_packer_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEF_BYTES_PER_WORD = 4;
    localparam int DEF_WORD_W         = BYTE_W * DEF_BYTES_PER_WORD;
    localparam int MAX_LANES          = 32;

    // Entry layout matches the FIFO storage order: keep above data.
    typedef struct packed {
        logic [DEF_BYTES_PER_WORD-1:0] keep;
        logic [DEF_WORD_W-1:0]         data;
    } packed_word_t;

    // Keep mask for a word holding n_bytes valid bytes starting at lane 0.
    function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned n_bytes);
        logic [MAX_LANES-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i < n_bytes) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/dataflow_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push while full is accepted only alongside a pop.
module dataflow_sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    // Gating on empty keeps the output at zero after reset without resetting storage.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        // NOTE: defaults first so every path assigns each signal and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dataflow_byte_packer.sv
// Packs a byte stream little-endian into words and queues them for a valid/ready consumer.
module dataflow_byte_packer
    import dataflow_byte_packer_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [7:0]                         data_in,
    input  logic                               in_valid,
    input  logic                               flush,
    output logic [BYTE_W*BYTES_PER_WORD-1:0]   out_data,
    output logic [BYTES_PER_WORD-1:0]          out_keep,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH):0]        fill_level
);

    localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    logic [LANE_W-1:0]         lane_q, lane_d;
    logic [WORD_W-1:0]         word_q, word_d;
    logic                      overflow_q, overflow_d;
    logic [WORD_W-1:0]         word_next;
    logic [LANE_W:0]           count_next;
    logic                      push_req;
    logic [BYTES_PER_WORD-1:0] push_keep;
    logic                      fifo_full, fifo_empty;

    always_comb begin
        word_next  = word_q;
        count_next = {1'b0, lane_q};
        if (in_valid) begin
            word_next[lane_q*BYTE_W +: BYTE_W] = data_in;
            count_next = {1'b0, lane_q} + 1'b1;
        end

        // A flush merged with a completing byte still yields one push.
        push_req = (count_next == (LANE_W+1)'(BYTES_PER_WORD))
                || (flush && count_next != '0);
        push_keep = BYTES_PER_WORD'(lane_mask(int'(count_next)));

        if (push_req) begin
            lane_d = '0;
            word_d = '0;
        end else begin
            lane_d = count_next[LANE_W-1:0];
            word_d = word_next;
        end

        overflow_d = overflow_q || (push_req && fifo_full && !(out_ready && !fifo_empty));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q     <= '0;
            word_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
        end
    end

    dataflow_sync_fifo #(
        .WIDTH (WORD_W + BYTES_PER_WORD),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_req),
        .wr_data ({push_keep, word_next}),
        .pop     (out_ready),
        .rd_data ({out_keep, out_data}),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fill_level)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_dataflow_byte_packer.sv
// Self-checking bench: vector table plus hand-written overflow/reset sequences, scoreboard on pops.
module tb_dataflow_byte_packer;
    import dataflow_byte_packer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        in_valid;
    logic        flush;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic [2:0]  fill_level;

    int n_tests = 0;
    int n_fail  = 0;
    packed_word_t sb[$];

    dataflow_byte_packer #(.BYTES_PER_WORD(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .flush      (flush),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Words leave the DUT on edges where valid and ready are both high; sample on the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_word", {32'd0, out_data}, 64'd0);
            end else begin
                packed_word_t e;
                e = sb.pop_front();
                check("sb_data", {32'd0, out_data}, {32'd0, e.data});
                check("sb_keep", {60'd0, out_keep}, {60'd0, e.keep});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic f);
        in_valid = v;
        data_in  = d;
        flush    = f;
        step();
        in_valid = 1'b0;
        data_in  = 8'h00;
        flush    = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
        packed_word_t w;
        w.data = d;
        w.keep = k;
        sb.push_back(w);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 50 && sb.size() != 0; i++) step();
        step();
        check(name, 64'(sb.size()), 64'd0);
        check({name, "_level"}, {61'd0, fill_level}, 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        sb.delete();
        rst_n = 1'b1;
        step();
    endtask

    typedef struct {
        int          n;      // bytes to send
        logic [31:0] bytes;  // little-endian byte payload
        int          mode;   // 0: none, 1: flush with last byte, 2: flush alone after
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; data_in = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_data",  {32'd0, out_data}, 64'd0);
        check("rst_keep",  {60'd0, out_keep}, 64'd0);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_ovf",   {63'd0, overflow}, 64'd0);
        check("rst_level", {61'd0, fill_level}, 64'd0);
        rst_n = 1'b1;
        step();

        // Full word: one-cycle latency and valid for exactly one cycle when ready is high.
        out_ready = 1'b1;
        expect_word(32'h44332211, 4'hF);
        drive(1, 8'h11, 0); drive(1, 8'h22, 0); drive(1, 8'h33, 0);
        check("w1_not_early", {63'd0, out_valid}, 64'd0);
        drive(1, 8'h44, 0);
        check("w1_valid",  {63'd0, out_valid}, 64'd1);
        check("w1_data",   {32'd0, out_data}, 64'h44332211);
        check("w1_level",  {61'd0, fill_level}, 64'd1);
        step();
        check("w1_one_cycle", {63'd0, out_valid}, 64'd0);

        // Partial flush followed by a flush on an empty assembler.
        expect_word(32'h0000BBAA, 4'b0011);
        drive(1, 8'hAA, 0); drive(1, 8'hBB, 0); drive(0, 8'h00, 1);
        check("pf_keep", {60'd0, out_keep}, 64'd3);
        drive(0, 8'h00, 1);
        check("pf_empty_flush", {61'd0, fill_level}, 64'd0);
        wait_drain("pf_drain");

        vecs[0] = '{4, 32'h44332211, 0, 32'h44332211, 4'b1111};
        vecs[1] = '{2, 32'h0000BBAA, 2, 32'h0000BBAA, 4'b0011};
        vecs[2] = '{3, 32'h00CCBBAA, 1, 32'h00CCBBAA, 4'b0111};
        vecs[3] = '{1, 32'h0000005A, 2, 32'h0000005A, 4'b0001};
        vecs[4] = '{4, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4'b1111};
        vecs[5] = '{3, 32'h00030201, 2, 32'h00030201, 4'b0111};
        vecs[6] = '{0, 32'h00000000, 2, 32'h00000000, 4'b0000};
        vecs[7] = '{1, 32'h00000077, 1, 32'h00000077, 4'b0001};
        for (int v = 0; v < 8; v++) begin
            logic [31:0] b;
            b = vecs[v].bytes;
            if (vecs[v].n > 0) expect_word(vecs[v].exp_data, vecs[v].exp_keep);
            for (int i = 0; i < vecs[v].n; i++)
                drive(1, b[8*i +: 8], (vecs[v].mode == 1) && (i == vecs[v].n - 1));
            if (vecs[v].mode == 2) drive(0, 8'h00, 1);
            wait_drain($sformatf("vec%0d_drain", v));
        end

        // Overflow: five words into a four-entry FIFO with the consumer stalled.
        out_ready = 1'b0;
        for (int w = 0; w < 5; w++) begin
            logic [7:0] base;
            base = 8'(4 * w);
            if (w < 4) expect_word({base + 8'd4, base + 8'd3, base + 8'd2, base + 8'd1}, 4'hF);
            for (int i = 0; i < 4; i++) drive(1, base + 8'(i + 1), 0);
            if (w == 3) check("ovf_not_yet", {63'd0, overflow}, 64'd0);
        end
        check("ovf_level", {61'd0, fill_level}, 64'd4);
        check("ovf_flag",  {63'd0, overflow}, 64'd1);
        check("ovf_head",  {32'd0, out_data}, 64'h04030201);
        out_ready = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_sticky", {63'd0, overflow}, 64'd1);

        // Full FIFO with a pop in the same edge as a completing word: nothing dropped.
        do_reset();
        out_ready = 1'b0;
        for (int w = 0; w < 5; w++) begin
            logic [7:0] base;
            base = 8'(16 + 4 * w);
            expect_word({base + 8'd4, base + 8'd3, base + 8'd2, base + 8'd1}, 4'hF);
            for (int i = 0; i < 4; i++) begin
                if (w == 4 && i == 3) out_ready = 1'b1;
                drive(1, base + 8'(i + 1), 0);
            end
        end
        out_ready = 1'b0;
        check("fwp_level", {61'd0, fill_level}, 64'd4);
        check("fwp_ovf",   {63'd0, overflow}, 64'd0);
        step();
        check("fwp_stable", {32'd0, out_data}, 64'h18171615);
        out_ready = 1'b1;
        wait_drain("fwp_drain");

        // Reset mid-operation: two queued words and a partial word are discarded.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) drive(1, 8'(8'hA0 + i), 0);
        check("mr_level_pre", {61'd0, fill_level}, 64'd2);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mr_data",  {32'd0, out_data}, 64'd0);
        check("mr_keep",  {60'd0, out_keep}, 64'd0);
        check("mr_valid", {63'd0, out_valid}, 64'd0);
        check("mr_level", {61'd0, fill_level}, 64'd0);
        #3;
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        expect_word(32'h04030201, 4'hF);
        drive(1, 8'h01, 0); drive(1, 8'h02, 0); drive(1, 8'h03, 0); drive(1, 8'h04, 0);
        check("mr_after_data", {32'd0, out_data}, 64'h04030201);
        wait_drain("mr_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
